// File: rtl/k_and_s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : k_and_s_pkg
// Description : Shared types and constants for the K&S processor control path
//               and datapath: decoded instruction encoding, controller state
//               encoding and ALU operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package k_and_s_pkg;

    // Instruction classes produced by the datapath decoder
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    // Controller states, explicit 4-bit encoding
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        LOAD_IR = 4'd1,
        DECODE  = 4'd2,
        LD_WAIT = 4'd3,
        LD_WB   = 4'd4,
        STORE   = 4'd5,
        ALU     = 4'd6,
        BR      = 4'd7,
        HALT    = 4'd8
    } ctrl_state_t;

    // ALU operation select codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage : k_and_s_pkg
`default_nettype wire

// File: rtl/ks_control_unit_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : ks_branch_cond
// Description : Combinational branch resolution from the decoded branch
//               instruction and the four registered ALU flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ks_branch_cond
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type instr_i,
    input  logic                    zero_op_i,
    input  logic                    neg_op_i,
    input  logic                    unsigned_overflow_i,
    input  logic                    signed_overflow_i,
    output logic                    taken_o
);

    // Signed overflow is carried through for a future BSOV-style branch;
    // none of the current conditions depend on it.
    logic w_unused_sov;
    assign w_unused_sov = signed_overflow_i;

    // Select the flag condition matching the branch flavour
    always_comb begin
        taken_o = 1'b0;
        case (instr_i)
            I_BRANCH: taken_o = 1'b1;
            I_BZERO:  taken_o = zero_op_i;
            I_BNZERO: taken_o = ~zero_op_i;
            I_BNEG:   taken_o = neg_op_i;
            I_BNNEG:  taken_o = ~neg_op_i;
            I_BOV:    taken_o = unsigned_overflow_i;
            I_BNOV:   taken_o = ~unsigned_overflow_i;
            default:  taken_o = 1'b0;
        endcase
    end

endmodule : ks_branch_cond
`default_nettype wire

// File: rtl/ks_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : ks_control_unit
// Description : Multi-cycle Moore controller for the K&S datapath. Sequences
//               fetch, decode, load/store, ALU, branch and halt, and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module ks_control_unit
    import k_and_s_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int RET_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction_i,
    input  logic                    zero_op_i,
    input  logic                    neg_op_i,
    input  logic                    unsigned_overflow_i,
    input  logic                    signed_overflow_i,
    output logic                    branch_o,
    output logic                    pc_enable_o,
    output logic                    ir_enable_o,
    output logic                    addr_sel_o,
    output logic                    c_sel_o,
    output logic [1:0]              operation_o,
    output logic                    write_reg_enable_o,
    output logic                    flags_reg_enable_o,
    output logic                    ram_write_enable_o,
    output logic                    halt_o,
    output logic [RET_W-1:0]        retired_o
);

    // Terminal count for the RAM wait counter (RAM_LATENCY is 1..3)
    localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

    ctrl_state_t      state_q,    state_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic [RET_W-1:0] retired_q,  retired_d;
    logic             w_taken;
    logic             w_retire;

    ks_branch_cond u_branch_cond (
        .instr_i             (decoded_instruction_i),
        .zero_op_i           (zero_op_i),
        .neg_op_i            (neg_op_i),
        .unsigned_overflow_i (unsigned_overflow_i),
        .signed_overflow_i   (signed_overflow_i),
        .taken_o             (w_taken)
    );

    // Next-state and RAM wait counter logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            FETCH, LD_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 2'd0;
                    state_d    = (state_q == FETCH) ? LOAD_IR : LD_WB;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            LOAD_IR: state_d = DECODE;
            DECODE: begin
                case (decoded_instruction_i)
                    I_LOAD:                          state_d = LD_WAIT;
                    I_STORE:                         state_d = STORE;
                    I_MOVE, I_ADD, I_SUB,
                    I_AND, I_OR:                     state_d = ALU;
                    I_BRANCH, I_BZERO, I_BNZERO,
                    I_BNEG, I_BNNEG, I_BOV, I_BNOV:  state_d = BR;
                    I_HALT:                          state_d = HALT;
                    default:                         state_d = FETCH;
                endcase
            end
            LD_WB, STORE, ALU, BR: state_d = FETCH;
            HALT:                  state_d = HALT;
            default:               state_d = FETCH;
        endcase
    end

    // An instruction retires when control returns to FETCH or first enters HALT
    always_comb begin
        w_retire  = ((state_d == FETCH) && (state_q != FETCH)) ||
                    ((state_d == HALT)  && (state_q != HALT));
        retired_d = w_retire ? (retired_q + RET_W'(1)) : retired_q;
    end

    // State, wait counter and retired counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_cnt_q <= 2'd0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    // Output decode from the current state; ALU op and branch come from the held IR
    always_comb begin
        branch_o           = 1'b0;
        pc_enable_o        = 1'b0;
        ir_enable_o        = 1'b0;
        addr_sel_o         = 1'b0;
        c_sel_o            = 1'b0;
        operation_o        = ALU_ADD;
        write_reg_enable_o = 1'b0;
        flags_reg_enable_o = 1'b0;
        ram_write_enable_o = 1'b0;
        halt_o             = 1'b0;
        case (state_q)
            LOAD_IR: begin
                ir_enable_o = 1'b1;
                pc_enable_o = 1'b1;
            end
            LD_WAIT: addr_sel_o = 1'b1;
            LD_WB: begin
                addr_sel_o         = 1'b1;
                c_sel_o            = 1'b1;
                write_reg_enable_o = 1'b1;
            end
            STORE: begin
                addr_sel_o         = 1'b1;
                ram_write_enable_o = 1'b1;
            end
            ALU: begin
                write_reg_enable_o = 1'b1;
                case (decoded_instruction_i)
                    I_ADD: begin operation_o = ALU_ADD; flags_reg_enable_o = 1'b1; end
                    I_SUB: begin operation_o = ALU_SUB; flags_reg_enable_o = 1'b1; end
                    I_AND: begin operation_o = ALU_AND; flags_reg_enable_o = 1'b1; end
                    I_OR:  begin operation_o = ALU_OR;  flags_reg_enable_o = 1'b1; end
                    // MOVE is A|A with the flags left untouched
                    default: operation_o = ALU_OR;
                endcase
            end
            BR: begin
                branch_o    = w_taken;
                pc_enable_o = w_taken;
            end
            HALT: halt_o = 1'b1;
            default: ;
        endcase
    end

    assign retired_o = retired_q;

endmodule : ks_control_unit
`default_nettype wire

// File: tb/tb_ks_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ks_control_unit
// Description : Directed self-checking bench for ks_control_unit with
//               RAM_LATENCY=2. Outputs are packed into one strobe vector:
//               {branch,pc_en,ir_en,addr_sel,c_sel,op[1:0],wre,fre,rwe,halt}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ks_control_unit;
    import k_and_s_pkg::*;

    localparam int RAM_LATENCY = 2;
    localparam int RET_W       = 16;

    // Packed strobe constants
    localparam logic [10:0] S_IDLE  = 11'h000;
    localparam logic [10:0] S_LDIR  = 11'h300;
    localparam logic [10:0] S_ADD   = 11'h00C;
    localparam logic [10:0] S_SUB   = 11'h01C;
    localparam logic [10:0] S_MOVE  = 11'h038;
    localparam logic [10:0] S_LDW   = 11'h080;
    localparam logic [10:0] S_LDWB  = 11'h0C8;
    localparam logic [10:0] S_STORE = 11'h082;
    localparam logic [10:0] S_BRT   = 11'h600;
    localparam logic [10:0] S_HALT  = 11'h001;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    decoded_instruction_type instr = I_NOP;
    logic                    zero_op = 1'b0;
    logic                    neg_op = 1'b0;
    logic                    uov = 1'b0;
    logic                    sov = 1'b0;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    wre, fre, rwe, halt;
    logic [RET_W-1:0]        retired;
    logic [10:0]             strobes;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ks_control_unit #(
        .RAM_LATENCY (RAM_LATENCY),
        .RET_W       (RET_W)
    ) u_dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .decoded_instruction_i (instr),
        .zero_op_i             (zero_op),
        .neg_op_i              (neg_op),
        .unsigned_overflow_i   (uov),
        .signed_overflow_i     (sov),
        .branch_o              (branch),
        .pc_enable_o           (pc_enable),
        .ir_enable_o           (ir_enable),
        .addr_sel_o            (addr_sel),
        .c_sel_o               (c_sel),
        .operation_o           (operation),
        .write_reg_enable_o    (wre),
        .flags_reg_enable_o    (fre),
        .ram_write_enable_o    (rwe),
        .halt_o                (halt),
        .retired_o             (retired)
    );

    assign strobes = {branch, pc_enable, ir_enable, addr_sel, c_sel,
                      operation, wre, fre, rwe, halt};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the first FETCH cycle, walk FETCH x2, LOAD_IR, DECODE with instr applied
    task automatic to_decode(input decoded_instruction_type ins);
        instr = ins;
        check("fetch0", 32'(strobes), 32'(S_IDLE));
        tick();
        check("fetch1", 32'(strobes), 32'(S_IDLE));
        tick();
        check("load_ir", 32'(strobes), 32'(S_LDIR));
        tick();
        check("decode", 32'(strobes), 32'(S_IDLE));
        tick();
    endtask

    initial begin
        // Reset held for three edges
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_strobes", 32'(strobes), 32'(S_IDLE));
        check("rst_retired", 32'(retired), 32'd0);

        // ADD
        to_decode(I_ADD);
        check("alu_add", 32'(strobes), 32'(S_ADD));
        check("alu_add_ret", 32'(retired), 32'd0);
        tick();
        check("add_ret", 32'(retired), 32'd1);

        // MOVE
        to_decode(I_MOVE);
        check("alu_move", 32'(strobes), 32'(S_MOVE));
        tick();
        check("move_ret", 32'(retired), 32'd2);

        // SUB
        to_decode(I_SUB);
        check("alu_sub", 32'(strobes), 32'(S_SUB));
        tick();

        // LOAD: two wait cycles then write-back
        to_decode(I_LOAD);
        check("ld_wait0", 32'(strobes), 32'(S_LDW));
        tick();
        check("ld_wait1", 32'(strobes), 32'(S_LDW));
        tick();
        check("ld_wb", 32'(strobes), 32'(S_LDWB));
        tick();
        check("ld_ret", 32'(retired), 32'd4);

        // Branch conditions: {instr, zero, neg, uov, expected}
        zero_op = 1'b1;
        to_decode(I_BZERO);
        check("bzero_t", 32'(strobes), 32'(S_BRT));
        tick();
        zero_op = 1'b0;
        to_decode(I_BZERO);
        check("bzero_nt", 32'(strobes), 32'(S_IDLE));
        tick();
        uov = 1'b1;
        to_decode(I_BNOV);
        check("bnov_nt", 32'(strobes), 32'(S_IDLE));
        tick();
        uov = 1'b0;
        neg_op = 1'b1;
        to_decode(I_BNEG);
        check("bneg_t", 32'(strobes), 32'(S_BRT));
        tick();
        neg_op = 1'b0;
        check("br_ret", 32'(retired), 32'd8);

        // STORE aborted by reset
        to_decode(I_STORE);
        check("store", 32'(strobes), 32'(S_STORE));
        rst_n = 1'b0;
        tick();
        check("store_rst_rwe", 32'(rwe), 32'd0);
        check("store_rst_ret", 32'(retired), 32'd0);
        rst_n = 1'b1;

        // NOP retires straight from DECODE
        to_decode(I_NOP);
        check("nop_fetch", 32'(strobes), 32'(S_IDLE));
        check("nop_ret", 32'(retired), 32'd1);

        // HALT is sticky
        to_decode(I_HALT);
        check("halt_ret", 32'(retired), 32'd2);
        instr = I_STORE;
        for (int i = 0; i < 22; i++) begin
            check("halt_hold", 32'(strobes), 32'(S_HALT));
            tick();
        end
        check("halt_ret_hold", 32'(retired), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time guard
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ks_control_unit
`default_nettype wire
